act_layer_mux: RTL

- Time-multiplexed, mode-selectable activation layer for a TOTAL-element feature vector.
- Processes LANES elements per cycle through LANES activation lanes and assembles the result into a registered output vector.
- Sits between a conv/affine stage and the next layer.
- Uses a start/valid handshake in place of a held-level load.

---
 rtl/act_layer_mux_if.sv | 27 ++
 rtl/act_layer_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/act_layer_mux_if.sv
// rtl/act_layer_mux_if.sv - handshake/data bundle for the activation layer mux
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

interface act_layer_mux_if #(
    parameter int TOTAL = 384,
    parameter int DW    = `DATA_LEN
);
    logic                  start;
    logic                  clear;
    logic [1:0]            mode;
    logic [TOTAL*DW-1:0]   d;
    logic                  busy;
    logic                  valid;
    logic [TOTAL*DW-1:0]   q;

    modport master (
        output start, clear, mode, d,
        input  busy, valid, q
    );

    modport slave (
        input  start, clear, mode, d,
        output busy, valid, q
    );
endinterface

// File: rtl/act_layer_mux.sv
// rtl/act_layer_mux.sv - time-multiplexed ELU/ReLU/bypass activation over a feature vector
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module act_layer_mux #(
    parameter int TOTAL   = 384,
    parameter int LANES   = 6,
    parameter int ELU_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    act_layer_mux_if.slave  bus
);
    localparam int DW = `DATA_LEN;
    localparam int N  = TOTAL / LANES;
    localparam int IW = $clog2(N) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [IW-1:0]       issue_idx;
    logic [IW-1:0]       wr_idx;
    logic [ELU_LAT:0]    pv;
    logic                busy_q;
    logic                valid_q;
    logic [TOTAL*DW-1:0] q_q;
    logic [DW-1:0]       lane_in [LANES];
    logic [DW-1:0]       pipe    [ELU_LAT][LANES];

    // Q8.8 ELU: negative inputs quantised to quarter-unit steps of |x|, saturating at -8.0
    function automatic logic [DW-1:0] elu_table(input logic [DW-1:0] x);
        logic [DW:0] mag;
        logic [4:0]  idx;
        logic [8:0]  m;
        mag = -{x[DW-1], x};
        idx = (|mag[DW:11]) ? 5'd31 : mag[10:6];
        case (idx)
            5'd0:  m = 9'd0;
            5'd1:  m = 9'd57;
            5'd2:  m = 9'd101;
            5'd3:  m = 9'd135;
            5'd4:  m = 9'd162;
            5'd5:  m = 9'd183;
            5'd6:  m = 9'd199;
            5'd7:  m = 9'd212;
            5'd8:  m = 9'd221;
            5'd9:  m = 9'd229;
            5'd10: m = 9'd235;
            5'd11: m = 9'd240;
            5'd12: m = 9'd243;
            5'd13: m = 9'd246;
            5'd14: m = 9'd248;
            5'd15: m = 9'd250;
            5'd16: m = 9'd251;
            5'd17: m = 9'd252;
            5'd18: m = 9'd253;
            5'd19: m = 9'd254;
            5'd20: m = 9'd254;
            5'd21: m = 9'd255;
            5'd22: m = 9'd255;
            5'd23: m = 9'd255;
            5'd24: m = 9'd255;
            default: m = 9'd256;
        endcase
        if (x[DW-1])
            elu_table = '0 - {{(DW-9){1'b0}}, m};
        else
            elu_table = x;
    endfunction

    function automatic logic [DW-1:0] lane_fn(input logic [1:0] md, input logic [DW-1:0] x);
        case (md)
            2'd0:    lane_fn = elu_table(x);
            2'd1:    lane_fn = x[DW-1] ? '0 : x;
            default: lane_fn = x;
        endcase
    endfunction

    // Sequencer, lane pipelines and result assembly; all paths share the same ELU_LAT delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= '0;
            issue_idx <= '0;
            wr_idx    <= '0;
            pv        <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            q_q       <= '0;
            for (int l = 0; l < LANES; l++) begin
                lane_in[l] <= '0;
                for (int s = 0; s < ELU_LAT; s++) pipe[s][l] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            pv      <= {pv[ELU_LAT-1:0], state == RUN};
            for (int l = 0; l < LANES; l++) begin
                pipe[0][l] <= lane_fn(mode_q, lane_in[l]);
                for (int s = 1; s < ELU_LAT; s++) pipe[s][l] <= pipe[s-1][l];
            end

            // The tail of the valid shift register, not a count offset, selects the write slot
            if (pv[ELU_LAT] && !bus.clear) begin
                for (int l = 0; l < LANES; l++)
                    q_q[(int'(wr_idx) * LANES + l) * DW +: DW] <= pipe[ELU_LAT-1][l];
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == LAST) begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            end

            case (state)
                IDLE: begin
                    // A start coinciding with the completion pulse is not taken
                    if (bus.start && !valid_q) begin
                        state     <= RUN;
                        busy_q    <= 1'b1;
                        mode_q    <= bus.mode;
                        issue_idx <= '0;
                        wr_idx    <= '0;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++)
                        lane_in[l] <= bus.d[(int'(issue_idx) * LANES + l) * DW +: DW];
                    issue_idx <= issue_idx + 1'b1;
                    if (issue_idx == LAST) state <= DRAIN;
                end
                default: ;
            endcase

            if (bus.clear) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                valid_q   <= 1'b0;
                pv        <= '0;
                issue_idx <= '0;
                wr_idx    <= '0;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.q     = q_q;
endmodule
